// File: rtl/mm_tile_scheduler_pkg.sv
// rtl/mm_tile_scheduler_pkg.sv - shared types and widths for the MM engine scheduler and buffers
// Purpose: FSM state enum, buffer instruction struct, and the width localparams that
//   the scheduler, its output registers and the A/B buffers all agree on.
// Ports: none (package).
package mm_engine_pkg;

  localparam int N                    = 4;
  localparam int MEMORY_ADDRESS_BITS  = 64;
  localparam int MAX_MATRIX_LENGTH    = 4096;
  localparam int COUNTER_BITS         = $clog2(MAX_MATRIX_LENGTH + 1);
  localparam int REPEATS_COUNTER_BITS = $clog2(MAX_MATRIX_LENGTH / N + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE_A = 2'd1,
    ISSUE_B = 2'd2,
    DONE    = 2'd3
  } sched_state_e;

  typedef struct packed {
    logic [MEMORY_ADDRESS_BITS-1:0]  address;
    logic [COUNTER_BITS-1:0]         length;
    logic [REPEATS_COUNTER_BITS-1:0] repeats;
  } buffer_instr_t;

endpackage

// File: rtl/mm_tile_scheduler_if.sv
// rtl/mm_tile_scheduler_if.sv - valid/ready instruction channel towards one memory buffer
// Purpose: groups one buffer instruction handshake and its payload.
// Ports (master drives): valid, address, length, repeats; (slave drives): ready.
interface mm_tile_scheduler_if;
  import mm_engine_pkg::*;

  logic                            valid;
  logic                            ready;
  logic [MEMORY_ADDRESS_BITS-1:0]  address;
  logic [COUNTER_BITS-1:0]         length;
  logic [REPEATS_COUNTER_BITS-1:0] repeats;

  modport master (output valid, address, length, repeats, input ready);
  modport slave  (input valid, address, length, repeats, output ready);

endinterface

// File: rtl/mm_tile_scheduler_instr_out_reg.sv
// rtl/mm_tile_scheduler_instr_out_reg.sv - registered valid/ready holder for one buffer instruction
// Purpose: holds one buffer_instr_t with a registered valid; payload stays put until handshake.
// Ports: clk, reset (async, active-low), load (capture instr and raise valid), instr (payload in),
//   port (master side of the instruction channel).
module instr_out_reg
  import mm_engine_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load,
  input  buffer_instr_t              instr,
  mm_tile_scheduler_if.master        port
);

  logic          valid_q;
  buffer_instr_t instr_q;

  // A load in the same cycle as a handshake replaces the payload and keeps valid high,
  // giving one instruction per cycle when ready is held.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      instr_q <= '0;
    end else if (load) begin
      valid_q <= 1'b1;
      instr_q <= instr;
    end else if (port.ready) begin
      valid_q <= 1'b0;
    end
  end

  assign port.valid   = valid_q;
  assign port.address = instr_q.address;
  assign port.length  = instr_q.length;
  assign port.repeats = instr_q.repeats;

endmodule

// File: rtl/mm_tile_scheduler.sv
// rtl/mm_tile_scheduler.sv - job-level row/col tile sequencer for the sum-stationary MM engine
// Purpose: accepts a job (A base, B base, K, R, C), issues one A instruction per row tile
//   (repeats=C) followed by C B instructions (repeats=1), then pulses job_done.
// Ports: clk, reset (async, active-low); job_valid/job_ready + job_a_base, job_b_base,
//   job_length, job_row_tiles, job_col_tiles; a_instr, b_instr (instruction channels);
//   job_done (one-cycle pulse); busy (not idle).
// Option MM_SCHED_PERF_EN: adds stall_cycles and issue_cycles outputs.
module mm_tile_scheduler
  import mm_engine_pkg::*;
(
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            job_valid,
  output logic                            job_ready,
  input  logic [MEMORY_ADDRESS_BITS-1:0]  job_a_base,
  input  logic [MEMORY_ADDRESS_BITS-1:0]  job_b_base,
  input  logic [COUNTER_BITS-1:0]         job_length,
  input  logic [REPEATS_COUNTER_BITS-1:0] job_row_tiles,
  input  logic [REPEATS_COUNTER_BITS-1:0] job_col_tiles,
  mm_tile_scheduler_if.master             a_instr,
  mm_tile_scheduler_if.master             b_instr,
  output logic                            job_done,
  output logic                            busy
`ifdef MM_SCHED_PERF_EN
  ,
  output logic [31:0]                     stall_cycles,
  output logic [31:0]                     issue_cycles
`endif
);

  localparam logic [REPEATS_COUNTER_BITS-1:0] REP_ONE = REPEATS_COUNTER_BITS'(1);

  sched_state_e                    state_q, state_n;
  logic [MEMORY_ADDRESS_BITS-1:0]  a_addr_q, a_addr_n, b_addr_q, b_addr_n;
  logic [MEMORY_ADDRESS_BITS-1:0]  b_base_q, stride_q;
  logic [COUNTER_BITS-1:0]         length_q;
  logic [REPEATS_COUNTER_BITS-1:0] row_tiles_q, col_tiles_q;
  logic [REPEATS_COUNTER_BITS-1:0] i_q, i_n, j_q, j_n;
  logic                            accept, load_a, load_b, job_empty;
  buffer_instr_t                   a_next, b_next;

  assign job_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign job_done  = (state_q == DONE);
  assign job_empty = (job_row_tiles == '0) || (job_col_tiles == '0) || (job_length == '0);

  always_comb begin
    state_n  = state_q;
    i_n      = i_q;
    j_n      = j_q;
    a_addr_n = a_addr_q;
    b_addr_n = b_addr_q;
    accept   = 1'b0;
    load_a   = 1'b0;
    load_b   = 1'b0;
    a_next   = '0;
    b_next   = '0;
    case (state_q)
      IDLE: begin
        if (job_valid) begin
          accept = 1'b1;
          if (job_empty) begin
            state_n = DONE;
          end else begin
            state_n        = ISSUE_A;
            i_n            = '0;
            a_addr_n       = job_a_base;
            load_a         = 1'b1;
            a_next.address = job_a_base;
            a_next.length  = job_length;
            a_next.repeats = job_col_tiles;
          end
        end
      end
      ISSUE_A: begin
        // Loading B on the A handshake edge avoids a bubble between the channels.
        if (a_instr.ready) begin
          state_n        = ISSUE_B;
          j_n            = '0;
          b_addr_n       = b_base_q;
          load_b         = 1'b1;
          b_next.address = b_base_q;
          b_next.length  = length_q;
          b_next.repeats = REP_ONE;
        end
      end
      ISSUE_B: begin
        if (b_instr.ready) begin
          if (j_q == col_tiles_q - REP_ONE) begin
            if (i_q == row_tiles_q - REP_ONE) begin
              state_n = DONE;
            end else begin
              state_n        = ISSUE_A;
              i_n            = i_q + REP_ONE;
              a_addr_n       = a_addr_q + stride_q;
              load_a         = 1'b1;
              a_next.address = a_addr_q + stride_q;
              a_next.length  = length_q;
              a_next.repeats = col_tiles_q;
            end
          end else begin
            j_n            = j_q + REP_ONE;
            b_addr_n       = b_addr_q + stride_q;
            load_b         = 1'b1;
            b_next.address = b_addr_q + stride_q;
            b_next.length  = length_q;
            b_next.repeats = REP_ONE;
          end
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      a_addr_q    <= '0;
      b_addr_q    <= '0;
      b_base_q    <= '0;
      stride_q    <= '0;
      length_q    <= '0;
      row_tiles_q <= '0;
      col_tiles_q <= '0;
      i_q         <= '0;
      j_q         <= '0;
    end else begin
      state_q  <= state_n;
      a_addr_q <= a_addr_n;
      b_addr_q <= b_addr_n;
      i_q      <= i_n;
      j_q      <= j_n;
      if (accept) begin
        b_base_q    <= job_b_base;
        length_q    <= job_length;
        row_tiles_q <= job_row_tiles;
        col_tiles_q <= job_col_tiles;
        // Tile stride is fixed per job; addresses then advance by running adds only.
        stride_q    <= MEMORY_ADDRESS_BITS'(job_length) * MEMORY_ADDRESS_BITS'(N);
      end
    end
  end

  instr_out_reg u_a_out (
    .clk   (clk),
    .reset (reset),
    .load  (load_a),
    .instr (a_next),
    .port  (a_instr)
  );

  instr_out_reg u_b_out (
    .clk   (clk),
    .reset (reset),
    .load  (load_b),
    .instr (b_next),
    .port  (b_instr)
  );

`ifdef MM_SCHED_PERF_EN
  logic stall_now;
  assign stall_now = (a_instr.valid && !a_instr.ready) || (b_instr.valid && !b_instr.ready);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles <= '0;
      issue_cycles <= '0;
    end else if (accept) begin
      stall_cycles <= '0;
      issue_cycles <= '0;
    end else begin
      if (busy && (issue_cycles != '1)) issue_cycles <= issue_cycles + 32'd1;
      if (stall_now && (stall_cycles != '1)) stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mm_tile_scheduler.sv
// tb/tb_mm_tile_scheduler.sv - scoreboard bench for mm_tile_scheduler
module tb_mm_tile_scheduler;
  import mm_engine_pkg::*;

  localparam int PW = MEMORY_ADDRESS_BITS + COUNTER_BITS + REPEATS_COUNTER_BITS;

  typedef struct packed {
    logic          chan;
    logic [PW-1:0] pay;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic job_valid, job_ready, job_done, busy;
  logic [MEMORY_ADDRESS_BITS-1:0]  job_a_base, job_b_base;
  logic [COUNTER_BITS-1:0]         job_length;
  logic [REPEATS_COUNTER_BITS-1:0] job_row_tiles, job_col_tiles;
`ifdef MM_SCHED_PERF_EN
  logic [31:0] stall_cycles, issue_cycles;
`endif

  mm_tile_scheduler_if a_if();
  mm_tile_scheduler_if b_if();

  mm_tile_scheduler dut (
    .clk           (clk),
    .reset         (reset),
    .job_valid     (job_valid),
    .job_ready     (job_ready),
    .job_a_base    (job_a_base),
    .job_b_base    (job_b_base),
    .job_length    (job_length),
    .job_row_tiles (job_row_tiles),
    .job_col_tiles (job_col_tiles),
    .a_instr       (a_if),
    .b_instr       (b_if),
    .job_done      (job_done),
    .busy          (busy)
`ifdef MM_SCHED_PERF_EN
    ,
    .stall_cycles  (stall_cycles),
    .issue_cycles  (issue_cycles)
`endif
  );

  always #5 clk = ~clk;

  int   vectors = 0;
  int   miscompares = 0;
  int   done_count = 0;
  int   exp_done = 0;
  int   ready_mode = 0;
  int   stall_chan = 0;
  int   stall_left = 0;
  int   last_cycles = 0;
  logic [63:0] stall_addr = '0;
  exp_t q[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: every row tile emits its A, then all C col-tile Bs; tile t sits at base + t*N*K.
  task automatic model_push(input logic [63:0] a, input logic [63:0] b, input int k,
                            input int r, input int c);
    logic [63:0] stride;
    exp_t e;
    stride = 64'(N) * 64'(k);
    if (r != 0 && c != 0 && k != 0) begin
      for (int i = 0; i < r; i++) begin
        e.chan = 1'b0;
        e.pay  = {a + 64'(i) * stride, COUNTER_BITS'(k), REPEATS_COUNTER_BITS'(c)};
        q.push_back(e);
        for (int j = 0; j < c; j++) begin
          e.chan = 1'b1;
          e.pay  = {b + 64'(j) * stride, COUNTER_BITS'(k), REPEATS_COUNTER_BITS'(1)};
          q.push_back(e);
        end
      end
    end
    exp_done++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    a_if.ready = 1'b1;
    b_if.ready = 1'b1;
    if (ready_mode == 1) begin
      a_if.ready = ($urandom_range(0, 3) != 0);
      b_if.ready = ($urandom_range(0, 3) != 0);
    end else if (ready_mode == 2 && stall_left > 0) begin
      if (stall_chan == 0 && a_if.valid && a_if.address == stall_addr) begin
        a_if.ready = 1'b0;
        stall_left--;
      end
      if (stall_chan == 1 && b_if.valid && b_if.address == stall_addr) begin
        b_if.ready = 1'b0;
        stall_left--;
      end
    end
  endtask

  task automatic pop_compare(input logic chan, input logic [PW-1:0] pay);
    exp_t e;
    if (q.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL unexpected_instr: got chan %0d payload 0x%0h expected none", chan, pay);
    end else begin
      e = q.pop_front();
      check(chan ? "b_instr" : "a_instr", {chan, pay}, {e.chan, e.pay});
    end
  endtask

  task automatic monitor();
    logic          a_hold, b_hold;
    logic [PW-1:0] a_hv, b_hv, pa, pb;
    a_hold = 1'b0;
    b_hold = 1'b0;
    a_hv   = '0;
    b_hv   = '0;
    forever begin
      @(negedge clk);
      pa = {a_if.address, a_if.length, a_if.repeats};
      pb = {b_if.address, b_if.length, b_if.repeats};
      if (!reset) begin
        a_hold = 1'b0;
        b_hold = 1'b0;
      end else begin
        if (a_if.valid && b_if.valid) check("both_valid", 1, 0);
        if (a_hold) check("a_hold_stable", {a_if.valid, pa}, {1'b1, a_hv});
        if (b_hold) check("b_hold_stable", {b_if.valid, pb}, {1'b1, b_hv});
        if (a_if.valid && a_if.ready) pop_compare(1'b0, pa);
        if (b_if.valid && b_if.ready) pop_compare(1'b1, pb);
        a_hold = a_if.valid && !a_if.ready;
        b_hold = b_if.valid && !b_if.ready;
        a_hv   = pa;
        b_hv   = pb;
        if (job_done) begin
          check("job_done_expected", exp_done > 0, 1);
          if (exp_done > 0) exp_done--;
          done_count++;
        end
      end
    end
  endtask

  task automatic drive_job(input logic [63:0] a, input logic [63:0] b, input int k,
                           input int r, input int c);
    job_valid     = 1'b1;
    job_a_base    = a;
    job_b_base    = b;
    job_length    = COUNTER_BITS'(k);
    job_row_tiles = REPEATS_COUNTER_BITS'(r);
    job_col_tiles = REPEATS_COUNTER_BITS'(c);
  endtask

  task automatic run_job(input logic [63:0] a, input logic [63:0] b, input int k,
                         input int r, input int c);
    int start;
    int cycles;
    model_push(a, b, k, r, c);
    check("job_ready_idle", job_ready, 1);
    drive_job(a, b, k, r, c);
    start = done_count;
    tick();
    cycles = 0;
    while (done_count == start && cycles < 4000) begin
      // Garbage requests while busy must be ignored.
      if (busy && $urandom_range(0, 1) == 1)
        drive_job({$urandom, $urandom}, {$urandom, $urandom}, int'($urandom_range(0, 99)),
                  int'($urandom_range(0, 5)), int'($urandom_range(0, 5)));
      else
        job_valid = 1'b0;
      tick();
      cycles++;
    end
    job_valid   = 1'b0;
    last_cycles = cycles;
    check("job_done_seen", done_count - start, 1);
    check("queue_drained", q.size(), 0);
    check("idle_after_done", {job_ready, busy}, 2'b10);
  endtask

  initial begin
    int n;
    reset         = 1'b0;
    job_valid     = 1'b0;
    job_a_base    = '0;
    job_b_base    = '0;
    job_length    = '0;
    job_row_tiles = '0;
    job_col_tiles = '0;
    a_if.ready    = 1'b0;
    b_if.ready    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_flags", {a_if.valid, b_if.valid, job_done, busy, job_ready}, 5'b00001);
    check("reset_a_payload", {a_if.address, a_if.length, a_if.repeats}, 0);
    check("reset_b_payload", {b_if.address, b_if.length, b_if.repeats}, 0);
    reset = 1'b1;
    fork
      monitor();
    join_none
    tick();

    // Basic 2x3 job, readies high: back-to-back issue with no bubbles.
    ready_mode = 0;
    run_job(64'h100, 64'h800, 8, 2, 3);
    check("b2b_cycles", last_cycles, 9);

    // Same job, 2nd B held off for 5 cycles.
    ready_mode = 2;
    stall_chan = 1;
    stall_addr = 64'h820;
    stall_left = 5;
    run_job(64'h100, 64'h800, 8, 2, 3);
    check("b_stall_consumed", stall_left, 0);
    ready_mode = 0;

    // Empty jobs: no instructions, prompt job_done.
    run_job(64'h100, 64'h800, 8, 0, 3);
    check("zero_r_latency", last_cycles <= 2, 1);
    run_job(64'h100, 64'h800, 8, 2, 0);
    check("zero_c_latency", last_cycles <= 2, 1);
    run_job(64'h100, 64'h800, 0, 2, 3);
    check("zero_k_latency", last_cycles <= 2, 1);

    // Address wrap: second A lands at 0.
    run_job(64'hFFFF_FFFF_FFFF_FFE0, 64'h40, 8, 2, 1);

    // Reset in the middle of ISSUE_B aborts the job.
    model_push(64'h100, 64'h800, 8, 2, 3);
    drive_job(64'h100, 64'h800, 8, 2, 3);
    tick();
    job_valid = 1'b0;
    n = 0;
    while (!b_if.valid && n < 50) begin
      tick();
      n++;
    end
    check("reached_issue_b", b_if.valid, 1);
    tick();
    reset = 1'b0;
    #1;
    check("abort_outputs", {a_if.valid, b_if.valid, busy, job_done}, 4'b0000);
    q.delete();
    exp_done = 0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    run_job(64'h100, 64'h800, 8, 2, 3);

`ifdef MM_SCHED_PERF_EN
    ready_mode = 2;
    stall_chan = 0;
    stall_addr = 64'h1000;
    stall_left = 4;
    run_job(64'h1000, 64'h2000, 16, 1, 1);
    check("perf_stall_cycles", stall_cycles, 4);
    check("perf_issue_cycles", issue_cycles, 7);
    ready_mode = 0;
`endif

    // Randomised jobs with random backpressure.
    ready_mode = 1;
    for (int t = 0; t < 30; t++) begin
      int r, c, k;
      r = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 4));
      c = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 4));
      k = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 300));
      run_job({$urandom, $urandom}, {$urandom, $urandom}, k, r, c);
    end

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
